imm_target_unit: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate generator in the 16-bit pipelined CPU.
- Sits between IF/ID and ID/EX. Each cycle it accepts one instruction word plus its PC, and emits:
  - the extended immediate,
  - an immediate class,
  - a precomputed control-flow target (branch: PC+1+offset; jump: PC-page plus 12-bit field).
- Supports stall and flush, and has a selectable latency of 1 or 2 stages.

---
 rtl/imm_target_unit_pkg.sv | 25 ++
 rtl/imm_target_unit_decode.sv | 33 +++
 rtl/imm_target_unit.sv | 121 ++++++++++++
 tb/tb_imm_target_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/imm_target_unit_pkg.sv
// imm_target_unit_pkg: shared word size, opcode values and immediate-class codes
// for the immediate/target unit of the 16-bit pipelined CPU.
package imm_target_unit_pkg;
    localparam int WORD_SIZE = 16;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;

    typedef enum logic [2:0] {
        KIND_NONE   = 3'd0,
        KIND_ZEXT   = 3'd1,
        KIND_SEXT   = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JUMP   = 3'd4
    } imm_kind_e;
endpackage

// File: rtl/imm_target_unit_decode.sv
// imm_decode: combinational instruction -> immediate class, extended immediate
// (raw sign-extended offset for branches) and jump field.
module imm_decode
    import imm_target_unit_pkg::*;
#(
    parameter int WORD_SIZE = imm_target_unit_pkg::WORD_SIZE,
    parameter int OFFSET_W  = 8,
    parameter int JTARGET_W = 12
) (
    input  logic [WORD_SIZE-1:0] instr,
    output imm_kind_e            kind,
    output logic [WORD_SIZE-1:0] ext,
    output logic [JTARGET_W-1:0] jfield
);
    logic [3:0]           op;
    logic [WORD_SIZE-1:0] zx, sx, jx;

    assign op     = instr[WORD_SIZE-1 -: 4];
    assign jfield = instr[JTARGET_W-1:0];
    assign zx     = {{(WORD_SIZE-OFFSET_W){1'b0}}, instr[OFFSET_W-1:0]};
    assign sx     = {{(WORD_SIZE-OFFSET_W){instr[OFFSET_W-1]}}, instr[OFFSET_W-1:0]};
    assign jx     = {{(WORD_SIZE-JTARGET_W){1'b0}}, instr[JTARGET_W-1:0]};

    always_comb begin
        kind = op inside {OP_LHI, OP_ORI}                 ? KIND_ZEXT   :
               op inside {OP_ADI, OP_LWD, OP_SWD}         ? KIND_SEXT   :
               op inside {OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ} ? KIND_BRANCH :
               op inside {OP_JMP, OP_JAL}                 ? KIND_JUMP   : KIND_NONE;
        ext  = kind == KIND_ZEXT                              ? zx :
               (kind == KIND_SEXT || kind == KIND_BRANCH)     ? sx :
               kind == KIND_JUMP                              ? jx : '0;
    end
endmodule

// File: rtl/imm_target_unit.sv
// imm_target_unit: pipelined immediate extender and branch/jump target precompute (1 or 2 stages).
// Optional IMM_TARGET_PERF_EN adds saturating branch/jump counters.
module imm_target_unit
    import imm_target_unit_pkg::*;
#(
    parameter int WORD_SIZE   = imm_target_unit_pkg::WORD_SIZE,
    parameter int OFFSET_W    = 8,
    parameter int JTARGET_W   = 12,
    parameter int PIPE_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] imm,
    output logic [2:0]           imm_kind,
    output logic [WORD_SIZE-1:0] target
`ifdef IMM_TARGET_PERF_EN
    ,
    output logic [15:0]          br_count,
    output logic [15:0]          jmp_count
`endif
);
    imm_kind_e            d_kind, s_kind, kind_q;
    logic [WORD_SIZE-1:0] d_ext, s_ext, s_pc, imm_d, target_d, imm_q, target_q;
    logic [JTARGET_W-1:0] d_jf, s_jf;
    logic                 s_valid, valid_q;

    imm_decode #(.WORD_SIZE(WORD_SIZE), .OFFSET_W(OFFSET_W), .JTARGET_W(JTARGET_W)) u_dec (
        .instr (instr),
        .kind  (d_kind),
        .ext   (d_ext),
        .jfield(d_jf)
    );

    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad
        $error("imm_target_unit: PIPE_STAGES must be 1 or 2");
    end

    if (PIPE_STAGES == 2) begin : g_two
        imm_kind_e            a_kind_q;
        logic [WORD_SIZE-1:0] a_ext_q, a_pc_q;
        logic [JTARGET_W-1:0] a_jf_q;
        logic                 a_valid_q;
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                a_valid_q <= 1'b0;
                a_kind_q  <= KIND_NONE;
                a_ext_q   <= '0;
                a_jf_q    <= '0;
                a_pc_q    <= '0;
            end else if (flush) begin
                a_valid_q <= 1'b0;
            end else if (!stall) begin
                a_valid_q <= in_valid;
                a_kind_q  <= d_kind;
                a_ext_q   <= d_ext;
                a_jf_q    <= d_jf;
                a_pc_q    <= pc;
            end
        end
        assign s_valid = a_valid_q;
        assign s_kind  = a_kind_q;
        assign s_ext   = a_ext_q;
        assign s_jf    = a_jf_q;
        assign s_pc    = a_pc_q;
    end else begin : g_one
        assign s_valid = in_valid;
        assign s_kind  = d_kind;
        assign s_ext   = d_ext;
        assign s_jf    = d_jf;
        assign s_pc    = pc;
    end

    // Branch immediate is relative to PC+1, so the +1 is folded into imm itself.
    always_comb begin
        imm_d    = s_kind == KIND_BRANCH ? s_ext + 1'b1 : s_ext;
        target_d = s_kind == KIND_BRANCH ? s_pc + imm_d :
                   s_kind == KIND_JUMP   ? {s_pc[WORD_SIZE-1:JTARGET_W], s_jf} : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            kind_q   <= KIND_NONE;
            imm_q    <= '0;
            target_q <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (!stall) begin
            valid_q  <= s_valid;
            kind_q   <= s_kind;
            imm_q    <= imm_d;
            target_q <= target_d;
        end
    end

    assign out_valid = valid_q;
    assign imm       = imm_q;
    assign target    = target_q;
    assign imm_kind  = valid_q ? kind_q : KIND_NONE;

`ifdef IMM_TARGET_PERF_EN
    logic [15:0] br_q, jmp_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            br_q  <= '0;
            jmp_q <= '0;
        end else if (!flush && !stall && s_valid) begin
            if (s_kind == KIND_BRANCH && br_q != 16'hFFFF) br_q <= br_q + 1'b1;
            if (s_kind == KIND_JUMP && jmp_q != 16'hFFFF) jmp_q <= jmp_q + 1'b1;
        end
    end
    assign br_count  = br_q;
    assign jmp_count = jmp_q;
`endif
endmodule

// File: tb/tb_imm_target_unit.sv
// tb_imm_target_unit: directed vectors against 1-stage and 2-stage instances sharing one input stream.
module tb_imm_target_unit;
    logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [15:0] instr = '0, pc = '0;
    logic        ov1, ov2;
    logic [15:0] imm1, imm2, tg1, tg2;
    logic [2:0]  k1, k2;
    int          n_vec = 0, n_err = 0;
`ifdef IMM_TARGET_PERF_EN
    logic [15:0] br1, br2, jc1, jc2;
`endif

    always #5 clk = ~clk;

    imm_target_unit #(.PIPE_STAGES(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .instr(instr), .pc(pc),
        .stall(stall), .flush(flush), .out_valid(ov1), .imm(imm1), .imm_kind(k1), .target(tg1)
`ifdef IMM_TARGET_PERF_EN
        , .br_count(br1), .jmp_count(jc1)
`endif
    );

    imm_target_unit #(.PIPE_STAGES(2)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .instr(instr), .pc(pc),
        .stall(stall), .flush(flush), .out_valid(ov2), .imm(imm2), .imm_kind(k2), .target(tg2)
`ifdef IMM_TARGET_PERF_EN
        , .br_count(br2), .jmp_count(jc2)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit two, input logic ev,
                              input logic [15:0] ei, input logic [2:0] ek, input logic [15:0] et);
        check({tag, ".valid"},  two ? 16'(ov2) : 16'(ov1), 16'(ev));
        check({tag, ".imm"},    two ? imm2 : imm1, ei);
        check({tag, ".kind"},   two ? 16'(k2) : 16'(k1), 16'(ek));
        check({tag, ".target"}, two ? tg2 : tg1, et);
    endtask

    task automatic expect_idle(input string tag, input bit two);
        check({tag, ".valid"}, two ? 16'(ov2) : 16'(ov1), 16'd0);
        check({tag, ".kind"},  two ? 16'(k2) : 16'(k1), 16'd0);
    endtask

    task automatic vec(input string tag, input logic [15:0] ins, input logic [15:0] p,
                       input logic [15:0] ei, input logic [2:0] ek, input logic [15:0] et);
        instr = ins; pc = p; in_valid = 1'b1;
        tick;
        expect_out({tag, "/s1"}, 1'b0, 1'b1, ei, ek, et);
        in_valid = 1'b0;
        tick;
        expect_out({tag, "/s2"}, 1'b1, 1'b1, ei, ek, et);
        expect_idle({tag, "/s1bub"}, 1'b0);
    endtask

    initial begin
        // reset held for two edges with a valid input present
        reset_n = 1'b0; in_valid = 1'b1; instr = 16'h01FE; pc = 16'h0010;
        tick; tick;
        expect_out("rst1", 1'b0, 1'b0, 16'h0000, 3'd0, 16'h0000);
        expect_out("rst2", 1'b1, 1'b0, 16'h0000, 3'd0, 16'h0000);
        reset_n = 1'b1;
        tick;
        expect_out("rel1", 1'b0, 1'b1, 16'hFFFF, 3'd3, 16'h000F);
        check("rel2.early", 16'(ov2), 16'd0);
        tick;
        expect_out("rel2", 1'b1, 1'b1, 16'hFFFF, 3'd3, 16'h000F);
        in_valid = 1'b0;
        tick; tick;

        vec("bne_back", 16'h01FE, 16'h0010, 16'hFFFF, 3'd3, 16'h000F);
        vec("beq_wrap", 16'h127F, 16'hFFF0, 16'h0080, 3'd3, 16'h0070);
        vec("blz_fwd",  16'h3205, 16'h0100, 16'h0006, 3'd3, 16'h0106);
        vec("jal",      16'hA345, 16'hA123, 16'h0345, 3'd4, 16'hA345);
        vec("jmp",      16'h9FFF, 16'h1234, 16'h0FFF, 3'd4, 16'h1FFF);
        vec("adi",      16'h4680, 16'h0040, 16'hFF80, 3'd2, 16'h0000);
        vec("lwd",      16'h7C90, 16'h0040, 16'hFF90, 3'd2, 16'h0000);
        vec("swd",      16'h8E01, 16'h0040, 16'h0001, 3'd2, 16'h0000);
        vec("ori",      16'h5680, 16'h0040, 16'h0080, 3'd1, 16'h0000);
        vec("lhi",      16'h6AFF, 16'h0040, 16'h00FF, 3'd1, 16'h0000);
        vec("rtype",    16'hF1C0, 16'h0040, 16'h0000, 3'd0, 16'h0000);
        vec("op11",     16'hB123, 16'h0040, 16'h0000, 3'd0, 16'h0000);

        // stall with a branch in flight; the input offered during the stall must not be taken
        tick;
        instr = 16'h2110; pc = 16'h0200; in_valid = 1'b1;
        tick;
        expect_out("stall0", 1'b0, 1'b1, 16'h0011, 3'd3, 16'h0211);
        stall = 1'b1; instr = 16'h4001; pc = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            tick;
            expect_out($sformatf("stall%0d", i + 1), 1'b0, 1'b1, 16'h0011, 3'd3, 16'h0211);
            expect_idle($sformatf("stall%0d_p2", i + 1), 1'b1);
        end
        stall = 1'b0; in_valid = 1'b0;
        tick;
        expect_idle("unstall_p1", 1'b0);
        expect_out("unstall_p2", 1'b1, 1'b1, 16'h0011, 3'd3, 16'h0211);

        // flush together with in_valid
        instr = 16'h9ABC; pc = 16'h5000; in_valid = 1'b1;
        tick;
        expect_out("preflush", 1'b0, 1'b1, 16'h0ABC, 3'd4, 16'h5ABC);
        flush = 1'b1; instr = 16'h4001;
        tick;
        expect_idle("flush_p1", 1'b0);
        expect_idle("flush_p2", 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        tick;
        expect_idle("postflush_p1", 1'b0);
        expect_idle("postflush_p2", 1'b1);
        tick;
        expect_idle("postflush2_p2", 1'b1);

        // reset beats stall and flush mid-operation
        instr = 16'h2110; pc = 16'h0200; in_valid = 1'b1;
        tick;
        reset_n = 1'b0; stall = 1'b1; flush = 1'b1;
        tick;
        expect_out("midrst_p1", 1'b0, 1'b0, 16'h0000, 3'd0, 16'h0000);
        expect_out("midrst_p2", 1'b1, 1'b0, 16'h0000, 3'd0, 16'h0000);
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick;

`ifdef IMM_TARGET_PERF_EN
        check("perf.br_rst", br1, 16'd0);
        check("perf.jmp_rst", jc2, 16'd0);
        instr = 16'h01FE; pc = 16'h0010; in_valid = 1'b1;
        tick; tick; tick;
        in_valid = 1'b0;
        tick;
        in_valid = 1'b1; flush = 1'b1;
        tick;
        flush = 1'b0; instr = 16'hA345;
        tick; tick;
        in_valid = 1'b0;
        tick; tick;
        check("perf.br1", br1, 16'd3);
        check("perf.br2", br2, 16'd3);
        check("perf.jmp1", jc1, 16'd2);
        check("perf.jmp2", jc2, 16'd2);
        instr = 16'h01FE; in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) tick;
        in_valid = 1'b0;
        tick; tick;
        check("perf.sat1", br1, 16'hFFFF);
        check("perf.sat2", br2, 16'hFFFF);
        check("perf.jmp_hold", jc1, 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
